// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Function : Job-level controller for one DSP MAC slice. It accepts a
//            dot-product job descriptor and issues operand pairs to the
//            slice. When the operand stream has a gap, it drains the slice
//            and re-seeds it with the shifted partial sum. It returns one
//            accumulated result per job.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer #(
  parameter int N  = 9,
  parameter int M  = 9,
  parameter int LW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  // job descriptor
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_mode,
  input  logic [LW-1:0]  cfg_len,
  input  logic [1:0]     cfg_shift,
  input  logic [N+M-1:0] cfg_init,
  // operand stream
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [N-1:0]   op_a,
  input  logic [M-1:0]   op_b,
  // result
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N+M-1:0] res_data,
  output logic           busy,
  // DSP slice control
  output logic           dsp_start,
  output logic           dsp_mac,
  output logic [1:0]     dsp_mode,
  output logic [1:0]     dsp_barrel_shifter,
  output logic [N-1:0]   dsp_aa,
  output logic [M-1:0]   dsp_bb,
  output logic [N+M-1:0] dsp_cc,
  input  logic [N+M-1:0] dsp_out,
  input  logic           dsp_valid
);

  localparam int             c_w            = N + M;
  localparam logic [1:0]     c_mode_illegal = 2'b11;
  localparam logic [LW-1:0]  c_len_one      = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [1:0]     shift_q, shift_d;
  logic [LW-1:0]  rem_q, rem_d;
  logic [2:0]     outst_q, outst_d;
  logic [c_w-1:0] seed_q, seed_d;
  logic [c_w-1:0] partial_q, partial_d;
  logic [c_w-1:0] res_q, res_d;

  logic           w_issue;
  logic           w_accept;

  // Registers for state, job fields, counters, seed, partial sum and result.
  // Reset clears everything, so the sequencer drops slice results that are still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      shift_q   <= '0;
      rem_q     <= '0;
      outst_q   <= '0;
      seed_q    <= '0;
      partial_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shift_q   <= shift_d;
      rem_q     <= rem_d;
      outst_q   <= outst_d;
      seed_q    <= seed_d;
      partial_q <= partial_d;
      res_q     <= res_d;
    end
  end

  // Next-state logic, handshakes and counter updates.
  // A mode-00 result returns in its own issue cycle, so that issue makes dsp_valid count
  // even when outstanding is zero.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    shift_d   = shift_q;
    rem_d     = rem_q;
    seed_d    = seed_q;
    partial_d = partial_q;
    res_d     = res_q;
    cfg_ready = 1'b0;
    res_valid = 1'b0;

    op_ready  = (state_q == S_RUN) && (rem_q != '0);
    w_issue   = op_ready && op_valid;
    w_accept  = dsp_valid && ((outst_q != 3'd0) || w_issue);
    outst_d   = outst_q + {2'b00, w_issue} - {2'b00, w_accept};

    if (w_accept) begin
      partial_d = dsp_out;
    end
    if (w_issue) begin
      rem_d = rem_q - c_len_one;
    end

    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          mode_d  = cfg_mode;
          shift_d = cfg_shift;
          rem_d   = cfg_len;
          seed_d  = cfg_init;
          if ((cfg_len == '0) || (cfg_mode == c_mode_illegal)) begin
            res_d   = cfg_init;
            state_d = S_RESULT;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!w_issue) begin
          // A segment that ends with nothing in flight and no pairs left is
          // already complete (mode 00). Report it without a drain cycle.
          if ((outst_q == 3'd0) && (rem_q == '0)) begin
            res_d   = partial_q;
            state_d = S_RESULT;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == 3'd0) begin
          if (rem_q == '0) begin
            res_d   = partial_q;
            state_d = S_RESULT;
          end else begin
            // The next segment starts from the shifted partial sum. This
            // keeps the per-step shift across the break.
            seed_d  = $signed(partial_q) >>> shift_q;
            state_d = S_RUN;
          end
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Slice issue controls. All slice data is forced to zero on cycles with no issue.
  assign dsp_start          = w_issue;
  assign dsp_mac            = w_issue;
  assign dsp_aa             = w_issue ? op_a   : '0;
  assign dsp_bb             = w_issue ? op_b   : '0;
  assign dsp_cc             = w_issue ? seed_q : '0;
  assign dsp_mode           = mode_q;
  assign dsp_barrel_shifter = shift_q;
  assign busy               = (state_q != S_IDLE);
  assign res_data           = res_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Function : Bench for dsp_mac_sequencer. A behavioural DSP slice stub
//            provides results at the mode-dependent latency. Job results are
//            compared against a plain-arithmetic dot-product model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;

  localparam int N  = 9;
  localparam int M  = 9;
  localparam int LW = 8;
  localparam int W  = N + M;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_mode = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [1:0]    cfg_shift = '0;
  logic [W-1:0]  cfg_init = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [N-1:0]  op_a = '0;
  logic [M-1:0]  op_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic          busy;
  logic          dsp_start, dsp_mac;
  logic [1:0]    dsp_mode, dsp_barrel_shifter;
  logic [N-1:0]  dsp_aa;
  logic [M-1:0]  dsp_bb;
  logic [W-1:0]  dsp_cc;
  logic [W-1:0]  dsp_out;
  logic          dsp_valid;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.N(N), .M(M), .LW(LW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_init(cfg_init),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
    .dsp_start(dsp_start), .dsp_mac(dsp_mac), .dsp_mode(dsp_mode),
    .dsp_barrel_shifter(dsp_barrel_shifter), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb),
    .dsp_cc(dsp_cc), .dsp_out(dsp_out), .dsp_valid(dsp_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Signed product of the operand fields that a slice mode uses, wrapped to W bits.
  function automatic logic [W-1:0] prod_f(input logic [1:0] mode, input logic [N-1:0] a,
                                          input logic [M-1:0] b);
    logic [W-1:0] sa, sb;
    if (mode != 2'b10 && mode != 2'b11) sa = {{(W-N/2-1){a[N/2]}}, a[N/2:0]};
    else                                sa = {{(W-N){a[N-1]}}, a};
    if (mode == 2'b00) sb = {{(W-M/2-1){b[M/2]}}, b[M/2:0]};
    else               sb = {{(W-M){b[M-1]}}, b};
    return sa * sb;
  endfunction

  // ---------------- behavioural DSP slice stub ----------------
  logic         mac_prev = 1'b0;
  logic [W-1:0] acc = '0;
  logic signed [W-1:0] acc_sh;
  logic [W-1:0] acc_next;
  logic         pl_v1 = 1'b0, pl_v2 = 1'b0, pl_v3 = 1'b0;
  logic [W-1:0] pl_d1 = '0, pl_d2 = '0, pl_d3 = '0;

  always_comb begin
    acc_sh   = $signed(acc) >>> dsp_barrel_shifter;
    acc_next = (mac_prev ? acc_sh : dsp_cc) + prod_f(dsp_mode, dsp_aa, dsp_bb);
  end

  always @(posedge clk) begin
    mac_prev <= dsp_mac;
    if (dsp_start) acc <= acc_next;
    pl_v1 <= pl_v2; pl_d1 <= pl_d2;
    pl_v2 <= pl_v3; pl_d2 <= pl_d3;
    pl_v3 <= 1'b0;
    if (dsp_start && dsp_mode == 2'b01) begin pl_v1 <= 1'b1; pl_d1 <= acc_next; end
    if (dsp_start && dsp_mode == 2'b10) begin pl_v3 <= 1'b1; pl_d3 <= acc_next; end
  end

  assign dsp_valid = (dsp_start && dsp_mode == 2'b00) || pl_v1;
  assign dsp_out   = (dsp_start && dsp_mode == 2'b00) ? acc_next : pl_d1;

  // ---------------- cycle monitor ----------------
  int           cyc = 0;
  int           issue_cyc[$];
  logic [W-1:0] seg_cc[$];
  logic         prev_mac_s = 1'b0;
  int           mac_bad = 0, idle_bad = 0, cfg_busy_bad = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dsp_start) begin
      issue_cyc.push_back(cyc);
      if (!prev_mac_s) seg_cc.push_back(dsp_cc);
    end
    if (dsp_mac !== dsp_start) mac_bad++;
    if (!dsp_start && (dsp_aa != '0 || dsp_bb != '0 || dsp_cc != '0)) idle_bad++;
    if (busy && cfg_ready) cfg_busy_bad++;
    if (!busy && (op_ready || res_valid)) idle_bad++;
    prev_mac_s = dsp_mac;
  end

  // ---------------- reference model ----------------
  logic [N-1:0] pa [256];
  logic [M-1:0] pb [256];

  function automatic logic [W-1:0] ref_f(input logic [1:0] mode, input int len,
                                         input logic [1:0] shift, input logic [W-1:0] init);
    logic signed [W-1:0] a;
    a = init;
    if (len == 0 || mode == 2'b11) return init;
    for (int i = 0; i < len; i++) begin
      if (i > 0) a = a >>> shift;
      a = a + prod_f(mode, pa[i], pb[i]);
    end
    return a;
  endfunction

  function automatic int lat_of(input logic [1:0] mode);
    return (mode == 2'b00) ? 0 : (mode == 2'b01) ? 1 : 3;
  endfunction

  // ---------------- job driver ----------------
  logic [W-1:0] j_res;
  int  j_nst, j_lat, j_cfg_lat, j_stable_bad, j_cfg_bad, seg_base;
  bit  j_done;

  task automatic run_job(input logic [1:0] mode, input int len, input logic [1:0] shift,
                         input logic [W-1:0] init, input int gap_pct, input int gap_at,
                         input int gap_len, input int hold);
    int base, idx, gap_left, rv_cnt, t_cfg, t_res, guard;
    bit gap_done;
    logic [W-1:0] first_data;
    base = issue_cyc.size(); seg_base = seg_cc.size();
    idx = 0; gap_left = 0; rv_cnt = 0; t_res = -1; guard = 0; gap_done = 0;
    first_data = '0; j_done = 0; j_stable_bad = 0; j_cfg_bad = 0; j_res = '0;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = mode; cfg_len = len[LW-1:0];
    cfg_shift = shift; cfg_init = init;
    @(negedge clk);
    while (!cfg_ready && guard < 50) begin @(negedge clk); guard++; end
    t_cfg = cyc;
    while (!j_done && guard < 400) begin
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      res_ready = (rv_cnt >= hold);
      if (idx == gap_at && !gap_done) begin gap_left = gap_len; gap_done = 1; end
      if (idx < len && gap_left == 0 && int'($urandom_range(99)) >= gap_pct) begin
        op_valid = 1'b1; op_a = pa[idx]; op_b = pb[idx];
      end else begin
        op_valid = 1'b0; op_a = N'($urandom); op_b = M'($urandom);
      end
      if (gap_left > 0) gap_left--;
      @(negedge clk); guard++;
      if (op_valid && op_ready) idx++;
      if (res_valid) begin
        if (t_res < 0) begin t_res = cyc; first_data = res_data; end
        else if (res_data !== first_data) j_stable_bad++;
        if (cfg_ready) j_cfg_bad++;
        rv_cnt++;
        if (res_ready) begin j_done = 1; j_res = res_data; end
      end
    end
    op_valid  = 1'b0;
    j_nst     = issue_cyc.size() - base;
    j_lat     = (j_nst > 0 && t_res >= 0) ? t_res - issue_cyc[base] : -1;
    j_cfg_lat = t_res - t_cfg;
  endtask

  task automatic job_chk(input string tag, input logic [1:0] mode, input int len,
                         input logic [1:0] shift, input logic [W-1:0] init, input int gap_pct,
                         input int gap_at, input int gap_len, input int hold, input bit chk_lat);
    logic [W-1:0] exp;
    int exp_n;
    exp   = ref_f(mode, len, shift, init);
    exp_n = (len == 0 || mode == 2'b11) ? 0 : len;
    run_job(mode, len, shift, init, gap_pct, gap_at, gap_len, hold);
    check_eq({tag, "_done"}, 32'(j_done), 32'd1);
    check_eq({tag, "_res"}, 32'(j_res), 32'(exp));
    check_eq({tag, "_nstart"}, j_nst, exp_n);
    check_eq({tag, "_stable"}, j_stable_bad, 0);
    check_eq({tag, "_cfg_in_result"}, j_cfg_bad, 0);
    if (exp_n == 0) check_eq({tag, "_cfg_to_res"}, j_cfg_lat, 1);
    else if (chk_lat) check_eq({tag, "_latency"}, j_lat, len + lat_of(mode) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_op_ready", 32'(op_ready), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_res_data", 32'(res_data), 32'd0);
    check_eq("rst_dsp_ctl", {26'd0, dsp_start, dsp_mac, dsp_mode, dsp_barrel_shifter}, 32'd0);
    rst_n = 1'b1;

    // Mode 10 back-to-back, including a negative operand.
    pa[0] = 9'd2; pb[0] = 9'd3; pa[1] = 9'd4; pb[1] = 9'd5; pa[2] = 9'h1FF; pb[2] = 9'd7;
    job_chk("m10_len3", 2'b10, 3, 2'd0, 18'd10, 0, -1, 0, 0, 1);
    check_eq("m10_len3_segs", seg_cc.size() - seg_base, 1);
    check_eq("m10_len3_cc", 32'(seg_cc[seg_base]), 32'd10);

    // Mode 01 with a two-cycle operand gap after the second pair.
    for (int i = 0; i < 4; i++) begin pa[i] = 9'd1; pb[i] = 9'd1; end
    job_chk("m01_gap", 2'b01, 4, 2'd0, 18'd0, 0, 2, 2, 0, 0);
    check_eq("m01_gap_val", 32'(j_res), 32'd4);
    check_eq("m01_gap_segs", seg_cc.size() - seg_base, 2);
    check_eq("m01_gap_cc2", 32'(seg_cc[seg_base+1]), 32'd2);

    // Mode 00 with shift: 9 + (9 >>> 1) = 13.
    pa[0] = 9'd3; pb[0] = 9'd3; pa[1] = 9'd3; pb[1] = 9'd3;
    job_chk("m00_shift", 2'b00, 2, 2'd1, 18'd0, 0, -1, 0, 0, 1);
    check_eq("m00_shift_val", 32'(j_res), 32'd13);

    // Zero length and illegal mode both return the initial addend.
    job_chk("len0", 2'b10, 0, 2'd0, 18'h3FFFB, 0, -1, 0, 0, 0);
    check_eq("len0_val", 32'(j_res), 32'h3FFFB);
    job_chk("mode11", 2'b11, 3, 2'd0, 18'h3FFFB, 0, -1, 0, 0, 0);
    check_eq("mode11_val", 32'(j_res), 32'h3FFFB);

    // Result back-pressure for five cycles.
    pa[0] = 9'd5; pb[0] = 9'h1FD; pa[1] = 9'd7; pb[1] = 9'd2;
    job_chk("hold5", 2'b10, 2, 2'd0, 18'd100, 0, -1, 0, 5, 1);
    @(posedge clk); #1;
    check_eq("hold5_cfg_ready_after", 32'(cfg_ready), 32'd1);

    // Reset while draining two mode-10 results.
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_len = 8'd6; cfg_shift = 2'd0; cfg_init = '0;
    @(negedge clk);
    @(posedge clk); #1;
    cfg_valid = 1'b0; op_valid = 1'b1; op_a = 9'd5; op_b = 9'd6;
    @(negedge clk);
    @(posedge clk); #1;
    op_a = 9'd7; op_b = 9'd8;
    @(negedge clk);
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check_eq("midrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("midrst_outs", {28'd0, op_ready, res_valid, dsp_start, dsp_mac}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_idle_after_stale", 32'(busy), 32'd0);
    pa[0] = 9'd2; pb[0] = 9'd2;
    job_chk("post_rst", 2'b10, 1, 2'd0, 18'd0, 0, -1, 0, 0, 1);
    check_eq("post_rst_val", 32'(j_res), 32'd4);

    // Randomized jobs.
    for (int k = 0; k < 25; k++) begin
      logic [1:0]   rm, rs;
      logic [W-1:0] ri;
      int           rl, gp;
      rm = 2'($urandom_range(3));
      rs = 2'($urandom_range(3));
      ri = W'($urandom);
      rl = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 8));
      gp = ($urandom_range(1) == 0) ? 0 : 35;
      for (int i = 0; i < rl; i++) begin pa[i] = N'($urandom); pb[i] = M'($urandom); end
      job_chk($sformatf("rnd%0d", k), rm, rl, rs, ri, gp, -1, 0,
              int'($urandom_range(3)), (gp == 0));
    end

    check_eq("mac_eq_start", mac_bad, 0);
    check_eq("idle_outputs", idle_bad, 0);
    check_eq("cfg_ready_busy", cfg_busy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
